sme_stream_driver: RTL and testbench
====================================

Name: sme_stream_driver

Overview:
- Initiator-side driver for the SME string-matching engine. It sits between a host/controller and SME's chardata/isstring/ispattern/valid/match/match_index interface.
- The host loads a string buffer and a pattern buffer and pulses start. The block serializes the bytes to SME, one per cycle, under the correct framing flag, then waits for valid and returns the captured result with a timeout guard.
- A string is re-sent only when it changed since its last transmission, so several patterns can be run against one string.

Parameters:
- STR_MAX, 32, string buffer depth in bytes (max string length).
- PAT_MAX, 8, pattern buffer depth in bytes.
- TIMEOUT, 1024, WAIT-state cycles without valid before the job is aborted.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_char  in  8  byte to append to a buffer.
- str_we  in  1  append wr_char to string buffer.
- pat_we  in  1  append wr_char to pattern buffer.
- clr  in  1  empty both buffers, clear err_overflow and str_dirty.
- start  in  1  one-cycle request to run the loaded pattern.
- busy  out  1  high from the cycle after start is accepted until the cycle after res_valid.
- chardata  out  8  byte to SME.
- isstring  out  1  chardata is a string byte.
- ispattern  out  1  chardata is a pattern byte.
- valid  in  1  SME result valid.
- match  in  1  SME match flag.
- match_index  in  5  SME match position.
- res_valid  out  1  one-cycle result strobe.
- res_match  out  1  captured match (0 on timeout).
- res_index  out  5  captured match_index (0 if no match or timeout).
- res_timeout  out  1  qualifies res_valid: job aborted, no valid seen.
- err_overflow  out  1  sticky: a write was dropped because the buffer was full, or a write/clr/start arrived while busy.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0: chardata, isstring, ispattern, busy, res_*, err_overflow. str_len=0, pat_len=0, str_dirty=0. Reset mid-job abandons the job immediately. No res_valid is produced.
- All outputs are registered.
- Writes (IDLE only):
  - str_we stores at str_len and increments it. It also sets str_dirty.
  - pat_we stores at pat_len and increments it.
  - A write at length==MAX is dropped and sets err_overflow.
  - str_we and pat_we together: both are performed.
  - A write and start in the same cycle: the write is performed first, and start uses the updated buffers.
- Writes, clr, or start while busy are ignored and set err_overflow.
- clr in IDLE takes priority over same-cycle writes/start.
- Start is accepted in IDLE only when pat_len>0 and (str_len>0 or a string was already sent). Otherwise it is ignored with no flag.
- FSM:
  - IDLE -> SEND_STR if str_dirty, else SEND_PAT.
  - SEND_STR: str_len cycles, chardata=str[i], isstring=1. Clears str_dirty on the last byte. Then goes to SEND_PAT.
  - SEND_PAT: pat_len cycles, chardata=pat[j], ispattern=1. Then goes to WAIT.
  - WAIT: isstring=ispattern=0, chardata holds the last byte. Counts cycles.
    - valid=1 -> capture match, and match_index masked to 0 when match=0. Go to REPORT.
    - Counter reaches TIMEOUT -> res_timeout=1, res_match=0. Go to REPORT.
    - valid and timeout in the same cycle: valid wins.
  - REPORT: res_valid=1 for exactly one cycle, then IDLE. busy drops the following cycle.
- Latency: start sampled at edge T gives the first byte on edge T+1. The last pattern byte is at edge T+N+M. WAIT begins at edge T+N+M+1.
- valid during SEND_STR/SEND_PAT/IDLE is ignored.
- res_match, res_index and res_timeout hold their values until the next res_valid.
- Buffers are preserved after a job, so start may be reissued directly.

Test Plan:
- String "abcde" (5 B), pattern "cd", start at cycle T:
  - isstring high for T+1..T+5 carrying 61..65.
  - ispattern high for T+6..T+7 carrying 63,64.
  - SME model returns valid=1, match=1, index=2 at T+10 -> res_valid at T+11 with res_match=1, res_index=2, busy low at T+12.
- Second job, new pattern "xy" only (string unchanged):
  - No isstring cycle; the first output is ispattern=1 with chardata=78 at T+1.
  - valid with match=0, index=7 -> res_match=0, res_index=0.
- Valid never asserted, TIMEOUT=16 -> res_valid with res_timeout=1 exactly 16 WAIT cycles after the last pattern byte.
- 33 str_we writes with STR_MAX=32 -> str_len=32, err_overflow=1. clr -> err_overflow=0, str_len=0.
- start with pat_len=0 -> no activity, busy stays 0.
- str_we during SEND_PAT -> the byte is not stored and err_overflow=1.
- Assert reset=0 mid SEND_STR -> isstring=0 and busy=0 asynchronously, no res_valid.
- After reset release, the buffers are empty.

Source files
------------

// File: rtl/sme_stream_driver.sv
// Initiator-side driver for the SME string-matching engine: buffers a string and a
// pattern from the host, streams them to SME under the right framing flag, and returns the result.
module sme_stream_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_char,
  input  logic       str_we,
  input  logic       pat_we,
  input  logic       clr,
  input  logic       start,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       err_overflow
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_STR = 3'd1;
  localparam logic [2:0] S_SEND_PAT = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_REPORT   = 3'd4;

  logic [7:0]     str_mem [STR_MAX];
  logic [7:0]     pat_mem [PAT_MAX];

  logic [2:0]     state;
  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len;
  logic           str_dirty;
  logic           str_sent;
  logic [SAW-1:0] str_idx;
  logic [PAW-1:0] pat_idx;
  logic [TW-1:0]  wait_cnt;
  logic           cap_match;
  logic           cap_timeout;
  logic [4:0]     cap_index;

  logic           idle_free;
  logic           str_full;
  logic           pat_full;
  logic           str_wr;
  logic           pat_wr;
  logic           start_ok;
  logic           host_err;
  logic           str_last;
  logic           pat_last;
  logic [SLW-1:0] str_len_nxt;
  logic [PLW-1:0] pat_len_nxt;

  // busy stays high one cycle into IDLE after the report, so host traffic is
  // only honoured once both the state and the busy flag say the block is free.
  assign idle_free   = (state == S_IDLE) && !busy;
  assign str_full    = (str_len == SLW'(STR_MAX));
  assign pat_full    = (pat_len == PLW'(PAT_MAX));
  assign str_wr      = idle_free && !clr && str_we && !str_full;
  assign pat_wr      = idle_free && !clr && pat_we && !pat_full;
  assign str_len_nxt = str_len + SLW'(str_wr);
  assign pat_len_nxt = pat_len + PLW'(pat_wr);

  // Start sees the buffers as updated by a write in the same cycle.
  assign start_ok = idle_free && !clr && start && (pat_len_nxt != '0) &&
                    ((str_len_nxt != '0) || str_sent);

  assign host_err = busy ? (str_we || pat_we || clr || start)
                         : (!clr && ((str_we && str_full) || (pat_we && pat_full)));

  assign str_last = ((SLW'(str_idx) + SLW'(1)) == str_len);
  assign pat_last = ((PLW'(pat_idx) + PLW'(1)) == pat_len);

  // NOTE: the byte buffers have no reset; str_len/pat_len alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (str_wr) str_mem[str_len[SAW-1:0]] <= wr_char;
    if (pat_wr) pat_mem[pat_len[PAW-1:0]] <= wr_char;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      chardata     <= '0;
      isstring     <= 1'b0;
      ispattern    <= 1'b0;
      res_valid    <= 1'b0;
      res_match    <= 1'b0;
      res_index    <= '0;
      res_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      str_len      <= '0;
      pat_len      <= '0;
      str_dirty    <= 1'b0;
      str_sent     <= 1'b0;
      str_idx      <= '0;
      pat_idx      <= '0;
      wait_cnt     <= '0;
      cap_match    <= 1'b0;
      cap_timeout  <= 1'b0;
      cap_index    <= '0;
    end else begin
      res_valid <= 1'b0;
      if (host_err) err_overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (clr) begin
            str_len      <= '0;
            pat_len      <= '0;
            str_dirty    <= 1'b0;
            err_overflow <= 1'b0;
          end else begin
            str_len <= str_len_nxt;
            pat_len <= pat_len_nxt;
            if (str_wr) str_dirty <= 1'b1;
            if (start_ok) begin
              busy    <= 1'b1;
              str_idx <= '0;
              pat_idx <= '0;
              state   <= (str_dirty || str_wr) ? S_SEND_STR : S_SEND_PAT;
            end
          end
        end

        S_SEND_STR: begin
          chardata  <= str_mem[str_idx];
          isstring  <= 1'b1;
          ispattern <= 1'b0;
          if (str_last) begin
            str_dirty <= 1'b0;
            str_sent  <= 1'b1;
            state     <= S_SEND_PAT;
          end else begin
            str_idx <= str_idx + SAW'(1);
          end
        end

        S_SEND_PAT: begin
          chardata  <= pat_mem[pat_idx];
          isstring  <= 1'b0;
          ispattern <= 1'b1;
          if (pat_last) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            pat_idx <= pat_idx + PAW'(1);
          end
        end

        // chardata is left untouched so it keeps the last pattern byte.
        S_WAIT: begin
          isstring  <= 1'b0;
          ispattern <= 1'b0;
          if (valid) begin
            cap_match   <= match;
            cap_index   <= match ? match_index : 5'd0;
            cap_timeout <= 1'b0;
            state       <= S_REPORT;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            cap_match   <= 1'b0;
            cap_index   <= 5'd0;
            cap_timeout <= 1'b1;
            state       <= S_REPORT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        S_REPORT: begin
          res_valid   <= 1'b1;
          res_match   <= cap_match;
          res_index   <= cap_index;
          res_timeout <= cap_timeout;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_stream_driver.sv
// Directed testbench for sme_stream_driver: framing, latency, results, timeout,
// overflow/busy error handling and asynchronous reset.
module tb_sme_stream_driver;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_char = '0;
  logic       str_we = 1'b0;
  logic       pat_we = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       match = 1'b0;
  logic [4:0] match_index = '0;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;
  logic       err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sme_stream_driver #(
    .STR_MAX(STR_MAX),
    .PAT_MAX(PAT_MAX),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_char(wr_char),
    .str_we(str_we),
    .pat_we(pat_we),
    .clr(clr),
    .start(start),
    .busy(busy),
    .chardata(chardata),
    .isstring(isstring),
    .ispattern(ispattern),
    .valid(valid),
    .match(match),
    .match_index(match_index),
    .res_valid(res_valid),
    .res_match(res_match),
    .res_index(res_index),
    .res_timeout(res_timeout),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_str(input logic [7:0] c);
    wr_char = c; str_we = 1'b1; tick(); str_we = 1'b0;
  endtask

  task automatic wr_pat(input logic [7:0] c);
    wr_char = c; pat_we = 1'b1; tick(); pat_we = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  // Runs one job with no SME response; optionally pokes str_we during SEND_PAT.
  task automatic run_job(input bit poke_str, output int n_str, output int n_pat,
                         output logic [7:0] first_s, output logic [7:0] last_s,
                         output bit done, output logic tmo);
    n_str = 0; n_pat = 0; first_s = '0; last_s = '0; done = 1'b0; tmo = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    if (poke_str) begin wr_char = 8'h55; str_we = 1'b1; end
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      str_we = 1'b0;
      if (isstring) begin
        if (n_str == 0) first_s = chardata;
        last_s = chardata;
        n_str++;
      end
      if (ispattern) n_pat++;
      if (res_valid) begin done = 1'b1; tmo = res_timeout; end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL run_job_done: res_valid not seen within 200 cycles");
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({busy, chardata, isstring, ispattern, res_valid, res_match, res_index,
         res_timeout, err_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b chardata=%h isstring=%b ispattern=%b res_valid=%b err=%b, all required 0",
               busy, chardata, isstring, ispattern, res_valid, err_overflow);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_c;
    wr_str(8'h61); wr_str(8'h62); wr_str(8'h63); wr_str(8'h64); wr_str(8'h65);
    wr_pat(8'h63); wr_pat(8'h64);
    start = 1'b1; tick(); start = 1'b0;                       // edge T
    n_checks++;
    if (busy !== 1'b1 || isstring !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_T: busy=%b isstring=%b, required busy=1 isstring=0", busy, isstring);
    end
    for (int k = 0; k < 5; k++) begin                          // T+1..T+5
      tick();
      exp_c = 8'h61 + 8'(k);
      n_checks++;
      if (isstring !== 1'b1 || ispattern !== 1'b0 || chardata !== exp_c) begin
        n_fail++;
        $display("FAIL basic_str%0d: isstring=%b ispattern=%b chardata=%h, required 1 0 %h",
                 k, isstring, ispattern, chardata, exp_c);
      end
    end
    for (int k = 0; k < 2; k++) begin                          // T+6..T+7
      tick();
      exp_c = 8'h63 + 8'(k);
      n_checks++;
      if (ispattern !== 1'b1 || isstring !== 1'b0 || chardata !== exp_c) begin
        n_fail++;
        $display("FAIL basic_pat%0d: isstring=%b ispattern=%b chardata=%h, required 0 1 %h",
                 k, isstring, ispattern, chardata, exp_c);
      end
    end
    tick();                                                    // T+8
    n_checks++;
    if (isstring !== 1'b0 || ispattern !== 1'b0 || chardata !== 8'h64) begin
      n_fail++;
      $display("FAIL basic_wait: isstring=%b ispattern=%b chardata=%h, required 0 0 64",
               isstring, ispattern, chardata);
    end
    tick();                                                    // T+9
    valid = 1'b1; match = 1'b1; match_index = 5'd2;
    tick();                                                    // T+10
    valid = 1'b0; match = 1'b0; match_index = '0;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_res: res_valid=%b at T+10, required 0", res_valid);
    end
    tick();                                                    // T+11
    n_checks++;
    if (res_valid !== 1'b1 || res_match !== 1'b1 || res_index !== 5'd2 ||
        res_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_result: res_valid=%b match=%b index=%0d timeout=%b busy=%b, required 1 1 2 0 1",
               res_valid, res_match, res_index, res_timeout, busy);
    end
    tick();                                                    // T+12
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_match !== 1'b1 || res_index !== 5'd2) begin
      n_fail++;
      $display("FAIL basic_after: res_valid=%b busy=%b match=%b index=%0d, required 0 0 1 2",
               res_valid, busy, res_match, res_index);
    end
  endtask

  task automatic test_pattern_only();
    do_clr();
    wr_pat(8'h78); wr_pat(8'h79);
    // valid held high through IDLE/SEND_PAT must be ignored there.
    valid = 1'b1; match = 1'b1; match_index = 5'd3;
    start = 1'b1; tick(); start = 1'b0;                       // T
    tick();                                                    // T+1
    n_checks++;
    if (ispattern !== 1'b1 || isstring !== 1'b0 || chardata !== 8'h78) begin
      n_fail++;
      $display("FAIL patonly_first: isstring=%b ispattern=%b chardata=%h, required 0 1 78",
               isstring, ispattern, chardata);
    end
    tick();                                                    // T+2
    n_checks++;
    if (ispattern !== 1'b1 || chardata !== 8'h79) begin
      n_fail++;
      $display("FAIL patonly_second: ispattern=%b chardata=%h, required 1 79", ispattern, chardata);
    end
    match = 1'b0; match_index = 5'd7;
    tick();                                                    // T+3: WAIT sees valid
    valid = 1'b0; match_index = '0;
    tick();                                                    // T+4
    n_checks++;
    if (res_valid !== 1'b1 || res_match !== 1'b0 || res_index !== 5'd0 || res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL patonly_result: res_valid=%b match=%b index=%0d timeout=%b, required 1 0 0 0",
               res_valid, res_match, res_index, res_timeout);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL patonly_idle: busy=%b err_overflow=%b, required 0 0", busy, err_overflow);
    end
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    start = 1'b1; tick(); start = 1'b0;                       // T, last pattern byte at T+2
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (res_valid) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL timeout_early: res_valid seen before T+19, required none");
    end
    tick();                                                    // T+19
    n_checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_match !== 1'b0 || res_index !== 5'd0) begin
      n_fail++;
      $display("FAIL timeout_result: res_valid=%b timeout=%b match=%b index=%0d, required 1 1 0 0",
               res_valid, res_timeout, res_match, res_index);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: res_valid=%b busy=%b timeout=%b, required 0 0 1",
               res_valid, busy, res_timeout);
    end
  endtask

  task automatic test_overflow();
    int n_s, n_p;
    logic [7:0] f_s, l_s;
    bit done;
    logic tmo;
    do_clr();
    for (int i = 0; i < 33; i++) wr_str(8'(i));
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_str_flag: err_overflow=%b, required 1", err_overflow);
    end
    wr_pat(8'h41);
    run_job(1'b0, n_s, n_p, f_s, l_s, done, tmo);
    n_checks++;
    if (n_s != 32 || f_s !== 8'h00 || l_s !== 8'h1f || n_p != 1 || tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_str_len: nstr=%0d first=%h last=%h npat=%0d tmo=%b, required 32 00 1f 1 1",
               n_s, f_s, l_s, n_p, tmo);
    end
    do_clr();
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: err_overflow=%b, required 0", err_overflow);
    end
    wr_str(8'h5a);
    for (int i = 0; i < 9; i++) wr_pat(8'h30 + 8'(i));
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pat_flag: err_overflow=%b, required 1", err_overflow);
    end
    run_job(1'b0, n_s, n_p, f_s, l_s, done, tmo);
    n_checks++;
    if (n_s != 1 || f_s !== 8'h5a || n_p != 8) begin
      n_fail++;
      $display("FAIL ovf_pat_len: nstr=%0d first=%h npat=%0d, required 1 5a 8", n_s, f_s, n_p);
    end
    do_clr();
  endtask

  task automatic test_no_pattern();
    bit moved;
    moved = 1'b0;
    wr_str(8'h31);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy || isstring || ispattern) moved = 1'b1;
      tick();
    end
    n_checks++;
    if (moved || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL nopat_ignored: activity=%b err_overflow=%b, required 0 0", moved, err_overflow);
    end
  endtask

  task automatic test_busy_write();
    int n_s, n_p;
    logic [7:0] f_s, l_s;
    bit done;
    logic tmo;
    wr_pat(8'h61); wr_pat(8'h62);
    run_job(1'b0, n_s, n_p, f_s, l_s, done, tmo);
    n_checks++;
    if (n_s != 1 || f_s !== 8'h31 || n_p != 2) begin
      n_fail++;
      $display("FAIL busy_first_job: nstr=%0d first=%h npat=%0d, required 1 31 2", n_s, f_s, n_p);
    end
    run_job(1'b1, n_s, n_p, f_s, l_s, done, tmo);
    n_checks++;
    if (n_s != 0 || n_p != 2 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_write_flag: nstr=%0d npat=%0d err_overflow=%b, required 0 2 1",
               n_s, n_p, err_overflow);
    end
    run_job(1'b0, n_s, n_p, f_s, l_s, done, tmo);
    n_checks++;
    if (n_s != 0) begin
      n_fail++;
      $display("FAIL busy_write_dropped: nstr=%0d, required 0 (string must not be dirty)", n_s);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n_s, n_p;
    logic [7:0] f_s, l_s;
    bit done;
    logic tmo;
    seen = 1'b0;
    do_clr();
    wr_str(8'h61); wr_str(8'h62); wr_str(8'h63); wr_str(8'h64);
    wr_pat(8'h61);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++;
    if (isstring !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_sending: isstring=%b, required 1", isstring);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (isstring !== 1'b0 || busy !== 1'b0 || chardata !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async: isstring=%b busy=%b chardata=%h, required 0 0 00",
               isstring, busy, chardata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_no_result: res_valid seen after reset, required none");
    end
    // Empty string buffer and no string sent: pattern-only start must be ignored.
    seen = 1'b0;
    wr_pat(8'h61);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_str_empty: busy seen, required 0");
    end
    // Empty pattern buffer: string-only start must be ignored.
    seen = 1'b0;
    do_clr();
    wr_str(8'h71);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_pat_empty: busy seen, required 0");
    end
    wr_pat(8'h72);
    run_job(1'b0, n_s, n_p, f_s, l_s, done, tmo);
    n_checks++;
    if (n_s != 1 || f_s !== 8'h71 || n_p != 1) begin
      n_fail++;
      $display("FAIL rstmid_recover: nstr=%0d first=%h npat=%0d, required 1 71 1", n_s, f_s, n_p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_pattern_only();
    test_timeout();
    test_overflow();
    test_no_pattern();
    test_busy_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
